// File: rtl/core_result_collector.sv
// Collects per-core results on the system clock: falling-edge completion detect,
// sticky result/stamp capture, registered grand total and a freezing cycle counter.
module core_result_collector #(
  parameter int CORES   = 4,
  parameter int DATA_W  = 8,
  parameter int CYCLE_W = 16,
  parameter int SUM_W   = DATA_W + 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CORES-1:0]         core_strobe,
  input  logic [CORES*DATA_W-1:0]  core_result,
  input  logic [2:0]               rd_sel,
  output logic [7:0]               done_mask,
  output logic                     all_done,
  output logic [SUM_W-1:0]         total,
  output logic [CYCLE_W-1:0]       cycles,
  output logic                     cyc_sat,
  output logic [DATA_W-1:0]        rd_result,
  output logic [CYCLE_W-1:0]       rd_stamp
);

  logic [CORES-1:0]   prev_q, prev_d;
  logic [CORES-1:0]   done_q, done_d;
  logic [DATA_W-1:0]  res_q   [CORES];
  logic [DATA_W-1:0]  res_d   [CORES];
  logic [CYCLE_W-1:0] stamp_q [CORES];
  logic [CYCLE_W-1:0] stamp_d [CORES];
  logic [SUM_W-1:0]   total_q, total_d;
  logic [CYCLE_W-1:0] cycles_q, cycles_d;
  logic               cyc_sat_q, cyc_sat_d;

  assign all_done = &done_q;

  // A completion is the strobe falling; only the first one per core is kept.
  always_comb begin
    prev_d  = core_strobe;
    done_d  = done_q;
    res_d   = res_q;
    stamp_d = stamp_q;
    for (int i = 0; i < CORES; i++) begin
      if (prev_q[i] && !core_strobe[i] && !done_q[i]) begin
        done_d[i]  = 1'b1;
        res_d[i]   = core_result[i*DATA_W +: DATA_W];
        stamp_d[i] = cycles_q;
      end
    end
  end

  always_comb begin
    total_d = '0;
    for (int i = 0; i < CORES; i++) begin
      if (done_q[i]) total_d = total_d + SUM_W'(res_q[i]);
    end
  end

  // Gate uses the pre-edge all_done, so the last completing edge still counts.
  always_comb begin
    cycles_d = cycles_q;
    if (!all_done && !(&cycles_q)) cycles_d = cycles_q + CYCLE_W'(1);
    cyc_sat_d = cyc_sat_q | (&cycles_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q    <= '0;
      done_q    <= '0;
      total_q   <= '0;
      cycles_q  <= '0;
      cyc_sat_q <= 1'b0;
      for (int i = 0; i < CORES; i++) begin
        res_q[i]   <= '0;
        stamp_q[i] <= '0;
      end
    end else begin
      prev_q    <= prev_d;
      done_q    <= done_d;
      total_q   <= total_d;
      cycles_q  <= cycles_d;
      cyc_sat_q <= cyc_sat_d;
      for (int i = 0; i < CORES; i++) begin
        res_q[i]   <= res_d[i];
        stamp_q[i] <= stamp_d[i];
      end
    end
  end

  assign done_mask = 8'(done_q);
  assign total     = total_q;
  assign cycles    = cycles_q;
  assign cyc_sat   = cyc_sat_q;

  always_comb begin
    rd_result = '0;
    rd_stamp  = '0;
    for (int i = 0; i < CORES; i++) begin
      if (rd_sel == 3'(i)) begin
        rd_result = res_q[i];
        rd_stamp  = stamp_q[i];
      end
    end
  end

endmodule

// File: tb/tb_core_result_collector.sv
// Directed and randomized checks of core_result_collector against a per-edge
// reference model of completions, stamps, totals and the cycle counter.
module tb_core_result_collector;

  localparam int MAXC = 65535;

  logic        clk = 1'b0;
  always #10 clk = ~clk;

  logic        reset_n;
  logic [3:0]  strobe;
  logic [31:0] result;
  logic [2:0]  rd_sel;
  logic [7:0]  done_mask;
  logic        all_done;
  logic [10:0] total;
  logic [15:0] cycles;
  logic        cyc_sat;
  logic [7:0]  rd_result;
  logic [15:0] rd_stamp;

  logic        s_reset_n;
  logic [3:0]  s_strobe;
  logic [31:0] s_result;
  logic [7:0]  s_done_mask;
  logic        s_all_done;
  logic [10:0] s_total;
  logic [3:0]  s_cycles;
  logic        s_cyc_sat;
  logic [7:0]  s_rd_result;
  logic [3:0]  s_rd_stamp;

  core_result_collector #(.CORES(4), .DATA_W(8), .CYCLE_W(16)) dut (
    .clk(clk), .reset(reset_n), .core_strobe(strobe), .core_result(result),
    .rd_sel(rd_sel), .done_mask(done_mask), .all_done(all_done), .total(total),
    .cycles(cycles), .cyc_sat(cyc_sat), .rd_result(rd_result), .rd_stamp(rd_stamp)
  );

  core_result_collector #(.CORES(4), .DATA_W(8), .CYCLE_W(4)) dut_sat (
    .clk(clk), .reset(s_reset_n), .core_strobe(s_strobe), .core_result(s_result),
    .rd_sel(rd_sel), .done_mask(s_done_mask), .all_done(s_all_done), .total(s_total),
    .cycles(s_cycles), .cyc_sat(s_cyc_sat), .rd_result(s_rd_result), .rd_stamp(s_rd_stamp)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: edge count since release, per-core completion edge/result/stamp.
  int         k;
  int         done_at [4];
  logic [7:0] m_res   [4];
  int         m_stamp [4];
  logic [3:0] m_prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counter value after edge kk: runs with k, freezes at the edge the last core finished.
  function automatic int exp_cycles_at(int kk);
    bit all = 1'b1;
    int last = 0;
    int v;
    for (int i = 0; i < 4; i++) begin
      if (done_at[i] == 0 || done_at[i] > kk) all = 1'b0;
      else if (done_at[i] > last) last = done_at[i];
    end
    v = all ? last : kk;
    return (v > MAXC) ? MAXC : v;
  endfunction

  task automatic model_reset();
    k = 0;
    m_prev = 4'b0;
    for (int i = 0; i < 4; i++) begin
      done_at[i] = 0;
      m_res[i]   = 8'h0;
      m_stamp[i] = 0;
    end
  endtask

  task automatic model_edge();
    k++;
    for (int i = 0; i < 4; i++) begin
      if (m_prev[i] && !strobe[i] && done_at[i] == 0) begin
        done_at[i] = k;
        m_res[i]   = result[i*8 +: 8];
        m_stamp[i] = exp_cycles_at(k - 1);
      end
    end
    m_prev = strobe;
  endtask

  task automatic check_all();
    logic [7:0]  exp_mask;
    logic [31:0] exp_total;
    int          ec;
    exp_mask  = 8'h0;
    exp_total = 0;
    for (int i = 0; i < 4; i++) begin
      if (done_at[i] != 0) exp_mask[i] = 1'b1;
      if (done_at[i] != 0 && done_at[i] < k) exp_total += 32'(m_res[i]);
    end
    ec = exp_cycles_at(k);
    chk("done_mask", 32'(done_mask), 32'(exp_mask));
    chk("all_done", 32'(all_done), 32'(exp_mask == 8'h0F));
    chk("total", 32'(total), exp_total);
    chk("cycles", 32'(cycles), ec);
    chk("cyc_sat", 32'(cyc_sat), 32'(ec == MAXC));
    for (int s = 0; s < 8; s++) begin
      rd_sel = 3'(s);
      #1;
      chk("rd_result", 32'(rd_result), (s < 4 && done_at[s] != 0) ? 32'(m_res[s]) : 0);
      chk("rd_stamp", 32'(rd_stamp), (s < 4 && done_at[s] != 0) ? m_stamp[s] : 0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    check_all();
  endtask

  // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n   = 1'b0;
    s_reset_n = 1'b0;
    strobe    = 4'h0;
    s_strobe  = 4'h0;
    result    = 32'h0;
    s_result  = 32'h0;
    rd_sel    = 3'd0;
    model_reset();
    #25;

    // Basic completion, one core every 100 edges.
    result = {8'd13, 8'd14, 8'd13, 8'd14};
    do_reset();
    for (int e = 1; e <= 402; e++) begin
      for (int i = 0; i < 4; i++) strobe[i] = (e == 100 * (i + 1) - 1);
      step();
      if (e == 100) chk("basic_mask_100", 32'(done_mask), 32'h01);
      if (e == 200) chk("basic_mask_200", 32'(done_mask), 32'h03);
      if (e == 300) chk("basic_mask_300", 32'(done_mask), 32'h07);
      if (e == 401) chk("basic_total", 32'(total), 32'h36);
    end
    chk("basic_mask", 32'(done_mask), 32'h0F);
    chk("basic_cycles", 32'(cycles), 400);
    for (int i = 0; i < 4; i++) begin
      rd_sel = 3'(i);
      #1;
      chk("basic_stamp", 32'(rd_stamp), 99 + 100 * i);
    end

    // Simultaneous completion at edge 50.
    result = {8'd4, 8'd3, 8'd2, 8'd1};
    do_reset();
    for (int e = 1; e <= 55; e++) begin
      strobe = (e == 49) ? 4'hF : 4'h0;
      step();
      if (e == 50) chk("simul_mask", 32'(done_mask), 32'h0F);
      if (e == 51) chk("simul_total", 32'(total), 10);
    end
    chk("simul_cycles", 32'(cycles), 50);
    for (int i = 0; i < 4; i++) begin
      rd_sel = 3'(i);
      #1;
      chk("simul_stamp", 32'(rd_stamp), 49);
    end

    // Sticky capture: second fall of core 1 is ignored.
    do_reset();
    for (int e = 1; e <= 45; e++) begin
      result = (e <= 20) ? 32'h0000_0700 : 32'h0000_0900;
      strobe = (e == 19 || e == 39) ? 4'h2 : 4'h0;
      step();
    end
    rd_sel = 3'd1;
    #1;
    chk("sticky_result", 32'(rd_result), 7);
    chk("sticky_stamp", 32'(rd_stamp), 19);

    // Strobe high across reset release counts only when it falls.
    strobe = 4'h1;
    result = 32'h0000_00A5;
    do_reset();
    for (int e = 1; e <= 8; e++) begin
      strobe = (e <= 4) ? 4'h1 : 4'h0;
      step();
      if (e == 5) begin
        rd_sel = 3'd0;
        #1;
        chk("hold_mask", 32'(done_mask), 32'h01);
        chk("hold_stamp", 32'(rd_stamp), 4);
      end
    end
    strobe = 4'h0;
    do_reset();
    for (int e = 1; e <= 10; e++) step();
    chk("low_mask", 32'(done_mask), 32'h00);

    // Reset mid-operation with two cores done.
    result = {8'd0, 8'd0, 8'd22, 8'd11};
    do_reset();
    for (int e = 1; e <= 300; e++) begin
      strobe = (e == 9) ? 4'h1 : (e == 19) ? 4'h2 : 4'h0;
      step();
    end
    chk("mid_cycles", 32'(cycles), 300);
    chk("mid_mask", 32'(done_mask), 32'h03);
    do_reset();
    chk("mid_rst_cycles", 32'(cycles), 0);
    chk("mid_rst_total", 32'(total), 0);
    step();
    chk("mid_edge1_cycles", 32'(cycles), 1);

    // Randomized completions and results.
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int e = 1; e <= 250; e++) begin
        result = $urandom;
        for (int i = 0; i < 4; i++) strobe[i] = ($urandom_range(0, 15) == 0);
        step();
      end
    end

    // Saturation on a 4-bit counter with core 0 never finishing.
    reset_n  = 1'b0;
    strobe   = 4'h0;
    s_result = {8'h11, 8'h33, 8'h5A, 8'hFF};
    @(negedge clk);
    s_reset_n = 1'b1;
    for (int kk = 1; kk <= 20; kk++) begin
      s_strobe = (kk == 2) ? 4'b1110 : 4'b0000;
      @(posedge clk);
      #1;
      chk("sat_cycles", 32'(s_cycles), (kk < 15) ? kk : 15);
      chk("sat_flag", 32'(s_cyc_sat), 32'(kk >= 15));
      chk("sat_all_done", 32'(s_all_done), 0);
      chk("sat_total", 32'(s_total), (kk >= 4) ? 32'h9E : 0);
      rd_sel = 3'd5;
      #1;
      chk("sat_rd5_result", 32'(s_rd_result), 0);
      chk("sat_rd5_stamp", 32'(s_rd_stamp), 0);
      rd_sel = 3'd1;
      #1;
      chk("sat_rd1_result", 32'(s_rd_result), (kk >= 3) ? 32'h5A : 0);
      chk("sat_rd1_stamp", 32'(s_rd_stamp), (kk >= 3) ? 2 : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
